// File: rtl/soc_system_cpu_cpu_ocimem_pkg.sv
// Shared types and default widths for the OCI debug-RAM arbiter.
package soc_system_cpu_cpu_ocimem_pkg;

   localparam int OCIMEM_ADDR_W = 8;
   localparam int OCIMEM_DATA_W = 32;

   // Arbiter access sequencing: grant in IDLE, read data return in RD,
   // completion handshake in DONE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Requester that owns the access in flight (also used for last-served).
   typedef enum logic {
      OWN_AV   = 1'b0,
      OWN_JTAG = 1'b1
   } owner_e;

endpackage

// File: rtl/soc_system_cpu_cpu_ocimem_jtag_latch.sv
// Single-entry pending register for JTAG debug accesses plus the sticky
// overflow flag. A strobe arriving while an entry waits (and is not being
// granted in that same cycle) is dropped and recorded in ovf.
module soc_system_cpu_cpu_ocimem_jtag_latch
   import soc_system_cpu_cpu_ocimem_pkg::*;
#(
   parameter int ADDR_W = OCIMEM_ADDR_W,
   parameter int DATA_W = OCIMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              jtag_req,
   input  logic              jtag_we,
   input  logic [ADDR_W-1:0] jtag_addr,
   input  logic [DATA_W-1:0] jtag_wdata,
   input  logic              grant,
   output logic              pending,
   output logic              pend_we,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_wdata,
   output logic              ovf
);

   logic              pending_q, pending_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ovf_q, ovf_d;

   // Next-state: a grant frees the slot, so a strobe in that same cycle refills it.
   always_comb begin
      pending_d = pending_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ovf_d     = ovf_q;
      if (grant) begin
         pending_d = 1'b0;
      end
      if (jtag_req) begin
         if (!pending_q || grant) begin
            pending_d = 1'b1;
            we_d      = jtag_we;
            addr_d    = jtag_addr;
            wdata_d   = jtag_wdata;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // Pending entry and overflow registers; ovf only clears on reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_q <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pending    = pending_q;
   assign pend_we    = we_q;
   assign pend_addr  = addr_q;
   assign pend_wdata = wdata_q;
   assign ovf        = ovf_q;

endmodule

// File: rtl/soc_system_cpu_cpu_ocimem_arb.sv
// Arbiter sharing the OCI debug RAM between the CPU Avalon-MM slave port and
// JTAG debug accesses. Ties between a present Avalon request and a pending
// JTAG entry are round-robin by default; defining OCIMEM_ARB_JTAG_PRIO_EN
// gives JTAG fixed priority instead.
// Handshake: av_waitrequest stays high while av_read|av_write is asserted
// until the DONE cycle of the Avalon-owned access; the master holds its
// request until it sees waitrequest low and the access completes that cycle.
// jtag_done is a single-cycle pulse in the DONE cycle of a JTAG access.
module soc_system_cpu_cpu_ocimem_arb
   import soc_system_cpu_cpu_ocimem_pkg::*;
#(
   parameter int ADDR_W = OCIMEM_ADDR_W,
   parameter int DATA_W = OCIMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              jtag_req,
   input  logic              jtag_we,
   input  logic [ADDR_W-1:0] jtag_addr,
   input  logic [DATA_W-1:0] jtag_wdata,
   output logic [DATA_W-1:0] jtag_rdata,
   output logic              jtag_done,
   output logic              jtag_ovf,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   output logic [DATA_W-1:0] av_readdata,
   output logic              av_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output state_e            dbg_state
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   logic [DATA_W-1:0] av_rdata_q, av_rdata_d;
   logic [DATA_W-1:0] jtag_rdata_q, jtag_rdata_d;

   logic              pend;
   logic              pend_we;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_wdata;
   logic              av_req;
   logic              pick_jtag;
   logic              grant_av;
   logic              grant_jtag;

   soc_system_cpu_cpu_ocimem_jtag_latch #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_jtag_latch (
      .clk        (clk),
      .reset_n    (reset_n),
      .jtag_req   (jtag_req),
      .jtag_we    (jtag_we),
      .jtag_addr  (jtag_addr),
      .jtag_wdata (jtag_wdata),
      .grant      (grant_jtag),
      .pending    (pend),
      .pend_we    (pend_we),
      .pend_addr  (pend_addr),
      .pend_wdata (pend_wdata),
      .ovf        (jtag_ovf)
   );

   // Grant selection in IDLE; read+write together counts as a write.
   always_comb begin
      av_req = av_read | av_write;
`ifdef OCIMEM_ARB_JTAG_PRIO_EN
      pick_jtag = pend;
`else
      pick_jtag = pend && (!av_req || (last_q == OWN_AV));
`endif
      grant_jtag = (state_q == ST_IDLE) && pick_jtag;
      grant_av   = (state_q == ST_IDLE) && av_req && !pick_jtag;
      ram_addr   = grant_jtag ? pend_addr : av_address;
      ram_wdata  = grant_jtag ? pend_wdata : av_writedata;
      ram_we     = reset_n && ((grant_av && av_write) || (grant_jtag && pend_we));
   end

   // Access sequencer next-state: grant, capture read data, complete.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      av_rdata_d   = av_rdata_q;
      jtag_rdata_d = jtag_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_jtag) begin
               owner_d = OWN_JTAG;
               last_d  = OWN_JTAG;
               state_d = pend_we ? ST_DONE : ST_RD;
            end else if (grant_av) begin
               owner_d = OWN_AV;
               last_d  = OWN_AV;
               state_d = av_write ? ST_DONE : ST_RD;
            end
         end
         ST_RD: begin
            if (owner_q == OWN_AV) begin
               av_rdata_d = ram_rdata;
            end else begin
               jtag_rdata_d = ram_rdata;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_AV;
         last_q       <= OWN_JTAG;
         av_rdata_q   <= '0;
         jtag_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         av_rdata_q   <= av_rdata_d;
         jtag_rdata_q <= jtag_rdata_d;
      end
   end

   assign av_readdata    = av_rdata_q;
   assign jtag_rdata     = jtag_rdata_q;
   assign jtag_done      = reset_n && (state_q == ST_DONE) && (owner_q == OWN_JTAG);
   assign av_waitrequest = !reset_n ||
                           (av_req && !((state_q == ST_DONE) && (owner_q == OWN_AV)));
   assign dbg_state      = state_q;

endmodule
